mcu_command_router: RTL
=======================

MCU_COMMAND_ROUTER -- requirements
Module: mcu_command_router

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, giving the number of stream channels (1..16).
REQ-002 SHALL have parameter ADDR_WIDTH, default 18, giving the playback address width.
REQ-003 SHALL have parameter ADDR_BYTES, default 3, giving the address payload byte count (8*ADDR_BYTES >= ADDR_WIDTH).
REQ-004 SHALL have ports: i_master_clk  in  1  sole clock; i_reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have decoder ports: i_rx_cmd  in  8  command byte; i_rx_cmd_valid  in  1  command strobe; i_rx_data  in  8  payload byte; i_rx_data_valid  in  1  payload strobe; i_rx_end  in  1  end-of-frame strobe; o_response_sent  out  1  frame-complete pulse.
REQ-006 SHALL have encoder ports: o_tx_data  out  8  byte; o_tx_data_request, o_tx_start_request, o_tx_end_request, o_tx_vsync_request, o_tx_interrupt_request  out  1 each  request pulses; i_tx_busy  in  1  encoder busy.
REQ-007 SHALL have status ports: i_status_vsync  in  1; i_status_interrupt  in  1; o_status_request  out  1  status sample pulse; i_status_data  in  8.
REQ-008 SHALL have sink ports: o_system_mode  out  2; o_system_mode_valid  out  1; o_ch_data  out  8  shared; o_ch_data_valid, o_ch_start, o_ch_end  out  CHANNELS each  one-hot per channel; o_playback_address  out  ADDR_WIDTH; o_playback_address_valid  out  1.

Function
REQ-009 SHALL decode commands in IDLE only: 0x00 status, 0x03 frame address, 0x07 set mode, 0x10+k stream to channel k for k<CHANNELS, anything else unknown.
REQ-010 SHALL use states IDLE, EVT_VSYNC, EVT_INT, STAT_WAIT_END, TX_START, TX_CMD, TX_BYTE, TX_END, MODE_DATA, MODE_WAIT_END, STREAM, ADDR, ADDR_WAIT_END, DRAIN, DONE.
REQ-011 SHALL latch rising edges of i_status_vsync and i_status_interrupt into separate pending flags, cleared on entry to EVT_VSYNC/EVT_INT respectively; an edge in the clearing cycle SHALL re-set the flag.
REQ-012 SHALL, in IDLE, give priority: i_rx_cmd_valid > pending vsync > pending interrupt.
REQ-013 SHALL pulse each tx request for exactly one cycle on state entry, ignore i_tx_busy in that cycle, and leave the state on the first later cycle with i_tx_busy=0.
REQ-014 Status: STAT_WAIT_END until i_rx_end; then TX_START; TX_CMD with o_tx_data=0x00 and o_status_request pulsed on entry; TX_BYTE with o_tx_data=i_status_data sampled the cycle after o_status_request; TX_END; DONE.
REQ-015 Unknown command: DRAIN until i_rx_end, then the same frame with byte sequence START, 0xFF, offending cmd, END.
REQ-016 Set mode: first payload byte in MODE_DATA drives o_system_mode=data[1:0] with 1-cycle-delayed o_system_mode_valid pulse; surplus bytes SHALL be ignored; i_rx_end in MODE_DATA/MODE_WAIT_END goes to DONE.
REQ-017 Stream k: o_ch_start[k] pulse 1 cycle after the command; each payload byte forwarded on o_ch_data with o_ch_data_valid[k] 1 cycle later; o_ch_end[k] pulse 1 cycle after i_rx_end; other channel bits SHALL stay 0.
REQ-018 Frame address: collect ADDR_BYTES bytes MSB-first in a shadow register; on i_rx_end after all bytes, commit low ADDR_WIDTH bits to o_playback_address and pulse o_playback_address_valid next cycle.
REQ-019 SHALL treat a short address frame (end before ADDR_BYTES bytes) as discarded: no valid pulse, o_playback_address unchanged.
REQ-020 SHALL pulse o_response_sent for one cycle, the cycle after DONE, for every command, DONE then IDLE.
REQ-021 SHALL ignore i_rx_cmd_valid outside IDLE.

Reset
REQ-022 On i_reset: state IDLE, pending flags and edge history 0, all pulse/valid outputs 0, o_system_mode 0, o_playback_address 0, o_tx_data 0.
REQ-023 Reset mid-frame SHALL abort without emitting o_ch_end, valid or response pulses.

Verification
REQ-024 Cmd 0x00, end, i_status_data=0xA5, busy 10 cycles per byte -> start, 0x00, 0xA5, end in order, one o_status_request, one o_response_sent.
REQ-025 Cmd 0x03, bytes 0x02,0x34,0x56, end -> o_playback_address=0x23456 with one valid pulse; repeat with 2 bytes -> no pulse, value held.
REQ-026 Cmd 0x11, 4 bytes, end (CHANNELS=2) -> o_ch_start[1], 4 o_ch_data_valid[1], o_ch_end[1]; bit 0 silent.
REQ-027 Vsync and interrupt edges same cycle while idle -> vsync request then interrupt request; cmd_valid same cycle as pending vsync -> command served first, vsync after.
REQ-028 Cmd 0x42, 2 bytes, end -> START, 0xFF, 0x42, END; reset during stream -> all outputs 0, no o_ch_end.

Source files
------------

// File: rtl/mcu_command_router_if.sv
// Decoder (rx) and encoder (tx) handshake bundle of the MCU command router.
// The router takes the slave view; the link/test side takes the master view.
interface mcu_command_router_if;
  logic [7:0] i_rx_cmd;
  logic       i_rx_cmd_valid;
  logic [7:0] i_rx_data;
  logic       i_rx_data_valid;
  logic       i_rx_end;
  logic       o_response_sent;

  logic [7:0] o_tx_data;
  logic       o_tx_data_request;
  logic       o_tx_start_request;
  logic       o_tx_end_request;
  logic       o_tx_vsync_request;
  logic       o_tx_interrupt_request;
  logic       i_tx_busy;

  modport slave (
    input  i_rx_cmd, i_rx_cmd_valid, i_rx_data, i_rx_data_valid, i_rx_end, i_tx_busy,
    output o_response_sent, o_tx_data, o_tx_data_request, o_tx_start_request,
           o_tx_end_request, o_tx_vsync_request, o_tx_interrupt_request
  );

  modport master (
    output i_rx_cmd, i_rx_cmd_valid, i_rx_data, i_rx_data_valid, i_rx_end, i_tx_busy,
    input  o_response_sent, o_tx_data, o_tx_data_request, o_tx_start_request,
           o_tx_end_request, o_tx_vsync_request, o_tx_interrupt_request
  );
endinterface

// File: rtl/mcu_command_router.sv
// Routes decoded MCU command frames to mode/stream/address sinks, and answers status
// queries, unknown commands and vsync/interrupt events through the frame encoder.
module mcu_command_router #(
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned ADDR_BYTES = 3
) (
  input  logic                  i_master_clk,
  input  logic                  i_reset,
  mcu_command_router_if.slave   rtr_bus,
  input  logic                  i_status_vsync,
  input  logic                  i_status_interrupt,
  output logic                  o_status_request,
  input  logic [7:0]            i_status_data,
  output logic [1:0]            o_system_mode,
  output logic                  o_system_mode_valid,
  output logic [7:0]            o_ch_data,
  output logic [CHANNELS-1:0]   o_ch_data_valid,
  output logic [CHANNELS-1:0]   o_ch_start,
  output logic [CHANNELS-1:0]   o_ch_end,
  output logic [ADDR_WIDTH-1:0] o_playback_address,
  output logic                  o_playback_address_valid
);

  localparam int unsigned CntW = $clog2(ADDR_BYTES + 1);
  localparam logic [CHANNELS-1:0] ChOne = CHANNELS'(1);
  localparam logic [CntW-1:0] CntLast = CntW'(ADDR_BYTES - 1);

  typedef enum logic [3:0] {
    StIdle, StEvtVsync, StEvtInt, StStatWaitEnd, StTxStart, StTxCmd, StTxByte, StTxEnd,
    StModeData, StModeWaitEnd, StStream, StAddr, StAddrWaitEnd, StDrain, StDone
  } state_e;

  state_e                state_q;
  logic                  tx_first_q;
  logic                  err_q;
  logic                  stat_req_q;
  logic [7:0]            tx_byte_q;
  logic [3:0]            ch_q;
  logic [CntW-1:0]       cnt_q;
  logic [ADDR_WIDTH-1:0] shadow_q;
  logic                  vsync_prev_q, int_prev_q;
  logic                  vsync_pend_q, int_pend_q;

  logic vsync_rise, int_rise, take_vsync, take_int, is_stream;

  always_comb begin
    vsync_rise = i_status_vsync & ~vsync_prev_q;
    int_rise   = i_status_interrupt & ~int_prev_q;
    take_vsync = (state_q == StIdle) && !rtr_bus.i_rx_cmd_valid && vsync_pend_q;
    take_int   = (state_q == StIdle) && !rtr_bus.i_rx_cmd_valid && !vsync_pend_q && int_pend_q;
    is_stream  = (rtr_bus.i_rx_cmd[7:4] == 4'h1) &&
                 ({1'b0, rtr_bus.i_rx_cmd[3:0]} < 5'(CHANNELS));
  end

  always_ff @(posedge i_master_clk) begin
    if (i_reset) begin
      state_q                        <= StIdle;
      tx_first_q                     <= 1'b0;
      err_q                          <= 1'b0;
      stat_req_q                     <= 1'b0;
      tx_byte_q                      <= 8'h00;
      ch_q                           <= 4'h0;
      cnt_q                          <= '0;
      shadow_q                       <= '0;
      vsync_prev_q                   <= 1'b0;
      int_prev_q                     <= 1'b0;
      vsync_pend_q                   <= 1'b0;
      int_pend_q                     <= 1'b0;
      rtr_bus.o_response_sent        <= 1'b0;
      rtr_bus.o_tx_data              <= 8'h00;
      rtr_bus.o_tx_data_request      <= 1'b0;
      rtr_bus.o_tx_start_request     <= 1'b0;
      rtr_bus.o_tx_end_request       <= 1'b0;
      rtr_bus.o_tx_vsync_request     <= 1'b0;
      rtr_bus.o_tx_interrupt_request <= 1'b0;
      o_status_request               <= 1'b0;
      o_system_mode                  <= 2'b00;
      o_system_mode_valid            <= 1'b0;
      o_ch_data                      <= 8'h00;
      o_ch_data_valid                <= '0;
      o_ch_start                     <= '0;
      o_ch_end                       <= '0;
      o_playback_address             <= '0;
      o_playback_address_valid       <= 1'b0;
    end else begin
      vsync_prev_q <= i_status_vsync;
      int_prev_q   <= i_status_interrupt;
      // An edge arriving in the clearing cycle must survive the clear.
      vsync_pend_q <= vsync_rise | (vsync_pend_q & ~take_vsync);
      int_pend_q   <= int_rise | (int_pend_q & ~take_int);

      rtr_bus.o_response_sent        <= 1'b0;
      rtr_bus.o_tx_data_request      <= 1'b0;
      rtr_bus.o_tx_start_request     <= 1'b0;
      rtr_bus.o_tx_end_request       <= 1'b0;
      rtr_bus.o_tx_vsync_request     <= 1'b0;
      rtr_bus.o_tx_interrupt_request <= 1'b0;
      o_status_request               <= 1'b0;
      o_system_mode_valid            <= 1'b0;
      o_ch_data_valid                <= '0;
      o_ch_start                     <= '0;
      o_ch_end                       <= '0;
      o_playback_address_valid       <= 1'b0;

      // Status byte is captured the cycle after the sample request.
      stat_req_q <= o_status_request;
      if (stat_req_q) tx_byte_q <= i_status_data;

      unique case (state_q)
        StIdle: begin
          if (rtr_bus.i_rx_cmd_valid) begin
            tx_byte_q <= rtr_bus.i_rx_cmd;
            err_q     <= 1'b0;
            if (rtr_bus.i_rx_cmd == 8'h00) begin
              state_q <= StStatWaitEnd;
            end else if (rtr_bus.i_rx_cmd == 8'h03) begin
              state_q <= StAddr;
              cnt_q   <= '0;
            end else if (rtr_bus.i_rx_cmd == 8'h07) begin
              state_q <= StModeData;
            end else if (is_stream) begin
              state_q    <= StStream;
              ch_q       <= rtr_bus.i_rx_cmd[3:0];
              o_ch_start <= ChOne << rtr_bus.i_rx_cmd[3:0];
            end else begin
              state_q <= StDrain;
              err_q   <= 1'b1;
            end
          end else if (take_vsync) begin
            state_q                    <= StEvtVsync;
            tx_first_q                 <= 1'b1;
            rtr_bus.o_tx_vsync_request <= 1'b1;
          end else if (take_int) begin
            state_q                        <= StEvtInt;
            tx_first_q                     <= 1'b1;
            rtr_bus.o_tx_interrupt_request <= 1'b1;
          end
        end
        StEvtVsync, StEvtInt: begin
          if (tx_first_q) tx_first_q <= 1'b0;
          else if (!rtr_bus.i_tx_busy) state_q <= StIdle;
        end
        StStatWaitEnd, StDrain: begin
          if (rtr_bus.i_rx_end) begin
            state_q                    <= StTxStart;
            tx_first_q                 <= 1'b1;
            rtr_bus.o_tx_start_request <= 1'b1;
          end
        end
        StTxStart: begin
          if (tx_first_q) begin
            tx_first_q <= 1'b0;
          end else if (!rtr_bus.i_tx_busy) begin
            state_q                   <= StTxCmd;
            tx_first_q                <= 1'b1;
            rtr_bus.o_tx_data         <= err_q ? 8'hFF : 8'h00;
            rtr_bus.o_tx_data_request <= 1'b1;
            o_status_request          <= ~err_q;
          end
        end
        StTxCmd: begin
          if (tx_first_q) begin
            tx_first_q <= 1'b0;
          end else if (!rtr_bus.i_tx_busy) begin
            state_q                   <= StTxByte;
            tx_first_q                <= 1'b1;
            rtr_bus.o_tx_data         <= stat_req_q ? i_status_data : tx_byte_q;
            rtr_bus.o_tx_data_request <= 1'b1;
          end
        end
        StTxByte: begin
          if (tx_first_q) begin
            tx_first_q <= 1'b0;
          end else if (!rtr_bus.i_tx_busy) begin
            state_q                  <= StTxEnd;
            tx_first_q               <= 1'b1;
            rtr_bus.o_tx_end_request <= 1'b1;
          end
        end
        StTxEnd: begin
          if (tx_first_q) tx_first_q <= 1'b0;
          else if (!rtr_bus.i_tx_busy) state_q <= StDone;
        end
        StModeData: begin
          if (rtr_bus.i_rx_data_valid) begin
            o_system_mode       <= rtr_bus.i_rx_data[1:0];
            o_system_mode_valid <= 1'b1;
            state_q             <= StModeWaitEnd;
          end
          if (rtr_bus.i_rx_end) state_q <= StDone;
        end
        StModeWaitEnd: begin
          if (rtr_bus.i_rx_end) state_q <= StDone;
        end
        StStream: begin
          if (rtr_bus.i_rx_data_valid) begin
            o_ch_data       <= rtr_bus.i_rx_data;
            o_ch_data_valid <= ChOne << ch_q;
          end
          if (rtr_bus.i_rx_end) begin
            o_ch_end <= ChOne << ch_q;
            state_q  <= StDone;
          end
        end
        StAddr: begin
          // An end before the last byte discards the frame.
          if (rtr_bus.i_rx_end) begin
            state_q <= StDone;
          end else if (rtr_bus.i_rx_data_valid) begin
            shadow_q <= (shadow_q << 8) | ADDR_WIDTH'(rtr_bus.i_rx_data);
            cnt_q    <= cnt_q + CntW'(1);
            if (cnt_q == CntLast) state_q <= StAddrWaitEnd;
          end
        end
        StAddrWaitEnd: begin
          if (rtr_bus.i_rx_end) begin
            o_playback_address       <= shadow_q;
            o_playback_address_valid <= 1'b1;
            state_q                  <= StDone;
          end
        end
        StDone: begin
          rtr_bus.o_response_sent <= 1'b1;
          state_q                 <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
